// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between instruction fetch
// and data access; holds each access across the busy window and aborts stuck ones.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_is_write,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_is_write,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_busy
);

  localparam int unsigned       CNT_W   = 16;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last_d, w_last_d_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
  logic                  r_if_ack, w_if_ack_nxt;
  logic                  r_if_err, w_if_err_nxt;
  logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata_nxt;
  logic                  r_d_ack, w_d_ack_nxt;
  logic                  r_d_err, w_d_err_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_mem_is_write, w_mem_is_write_nxt;
  logic [DATA_WIDTH-1:0] r_mem_data_out, w_mem_data_out_nxt;
  logic                  w_done, w_done_err;
  logic [DATA_WIDTH-1:0] w_done_data;

  // A master is not eligible in its own ack cycle, since it has not dropped req yet
  logic w_if_elig, w_d_elig, w_grant_d;
  assign w_if_elig = if_req && !r_if_ack;
  assign w_d_elig  = d_req && !r_d_ack;
  assign w_grant_d = w_d_elig && (!w_if_elig || !r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_d       <= 1'b0;
      r_cnt          <= '0;
      r_if_rdata     <= '0;
      r_if_ack       <= 1'b0;
      r_if_err       <= 1'b0;
      r_d_rdata      <= '0;
      r_d_ack        <= 1'b0;
      r_d_err        <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_is_write <= 1'b0;
      r_mem_data_out <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_d       <= w_last_d_nxt;
      r_cnt          <= w_cnt_nxt;
      r_if_rdata     <= w_if_rdata_nxt;
      r_if_ack       <= w_if_ack_nxt;
      r_if_err       <= w_if_err_nxt;
      r_d_rdata      <= w_d_rdata_nxt;
      r_d_ack        <= w_d_ack_nxt;
      r_d_err        <= w_d_err_nxt;
      r_mem_req      <= w_mem_req_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_is_write <= w_mem_is_write_nxt;
      r_mem_data_out <= w_mem_data_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_last_d_nxt       = r_last_d;
    w_cnt_nxt          = r_cnt;
    w_if_rdata_nxt     = r_if_rdata;
    w_if_ack_nxt       = 1'b0;
    w_if_err_nxt       = 1'b0;
    w_d_rdata_nxt      = r_d_rdata;
    w_d_ack_nxt        = 1'b0;
    w_d_err_nxt        = 1'b0;
    w_mem_req_nxt      = 1'b0;
    w_mem_addr_nxt     = r_mem_addr;
    w_mem_is_write_nxt = r_mem_is_write;
    w_mem_data_out_nxt = r_mem_data_out;
    w_done             = 1'b0;
    w_done_err         = 1'b0;
    w_done_data        = '0;

    case (r_state)
      S_IDLE: begin
        if (w_if_elig || w_d_elig) begin
          w_state_nxt        = S_ISSUE;
          w_mem_req_nxt      = 1'b1;
          w_last_d_nxt       = w_grant_d;
          w_mem_addr_nxt     = w_grant_d ? d_addr : if_addr;
          w_mem_is_write_nxt = w_grant_d && d_is_write;
          w_mem_data_out_nxt = w_grant_d ? d_wdata : r_mem_data_out;
        end
      end
      S_ISSUE: begin
        w_mem_req_nxt = mem_busy;
        if (!mem_busy) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        // r_cnt == 0 marks the first WAIT cycle, where the controller has not yet raised busy
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if ((r_cnt != '0) && !mem_busy) begin
          w_done      = 1'b1;
          w_done_data = r_mem_is_write ? '0 : mem_data_in;
        end else if (r_cnt == TO_LAST) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_done) begin
      w_state_nxt = S_IDLE;
      if (r_last_d) begin
        w_d_ack_nxt   = 1'b1;
        w_d_err_nxt   = w_done_err;
        w_d_rdata_nxt = w_done_data;
      end else begin
        w_if_ack_nxt   = 1'b1;
        w_if_err_nxt   = w_done_err;
        w_if_rdata_nxt = w_done_data;
      end
    end
  end

  assign if_rdata     = r_if_rdata;
  assign if_ack       = r_if_ack;
  assign if_err       = r_if_err;
  assign d_rdata      = r_d_rdata;
  assign d_ack        = r_d_ack;
  assign d_err        = r_d_err;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign mem_is_write = r_mem_is_write;
  assign mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-master traffic,
// checked against a transaction-level arbitration/memory model and a controller model.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_is_write;
  logic        if_ack, if_err, d_ack, d_err, mem_req, mem_is_write, mem_busy;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic [31:0] mem_addr, mem_data_out, mem_data_in;

  int n_chk = 0;
  int n_pass = 0;
  int busy_left = 0;
  int cur_busy = 1;
  int cfg_busy = 1;
  bit cfg_rand = 1'b0;
  bit hold_busy = 1'b0;
  bit to_mode = 1'b0;
  bit model_last_d = 1'b0;
  logic [31:0] ctl_mem [16];
  logic [31:0] ref_mem [16];
  bit ack_log [$];

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
  } txn_t;
  txn_t exp_q [$];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_is_write(d_is_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_is_write(mem_is_write),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  assign mem_busy = (busy_left > 0) || hold_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  // Controller model: busy for cur_busy cycles after each issue, data valid only at completion
  initial begin : ctl
    bit          issued, rst_s, compl, op_wr;
    logic [31:0] rd_val;
    op_wr = 1'b0;
    rd_val = '0;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      issued = mem_req && !mem_busy;
      rst_s  = rst;
      @(posedge clk);
      #1;
      compl = 1'b0;
      if (rst_s) busy_left = 0;
      else if (issued) begin
        cur_busy  = cfg_rand ? int'($urandom_range(1, 4)) : cfg_busy;
        busy_left = cur_busy;
        op_wr     = mem_is_write;
        rd_val    = ctl_mem[mem_addr[5:2]];
        if (mem_is_write) ctl_mem[mem_addr[5:2]] = mem_data_out;
      end else if (busy_left > 0) begin
        busy_left--;
        compl = (busy_left == 0);
      end
      mem_data_in = (compl && !op_wr) ? rd_val : 32'($urandom);
    end
  end

  // Transaction-level reference: arbitration rule at each grant, memory contents at each ack
  initial begin : mon
    int          cyc, iss_cyc;
    bit          p_mr, p_ei, p_ed, p_dwr;
    logic [31:0] p_ia, p_da, p_dw, exp_rd;
    txn_t        t;
    cyc = 0; iss_cyc = 0;
    p_mr = 0; p_ei = 0; p_ed = 0; p_dwr = 0;
    p_ia = '0; p_da = '0; p_dw = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        model_last_d = 1'b0;
        p_mr = 0; p_ei = 0; p_ed = 0;
      end else begin
        if (mem_req && !p_mr) begin
          chk("grant_elig", 64'(p_ei || p_ed), 64'(1));
          t.is_d  = (p_ei && p_ed) ? !model_last_d : p_ed;
          t.addr  = t.is_d ? p_da : p_ia;
          t.wr    = t.is_d && p_dwr;
          t.wdata = p_dw;
          model_last_d = t.is_d;
          chk("grant_addr", 64'(mem_addr), 64'(t.addr));
          chk("grant_wr", 64'(mem_is_write), 64'(t.wr));
          exp_q.push_back(t);
        end
        if (mem_req && !mem_busy) iss_cyc = cyc;
        if (if_ack || d_ack) begin
          chk("ack_excl", 64'(if_ack && d_ack), 64'(0));
          chk("ack_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            ack_log.push_back(d_ack);
            chk("ack_owner", 64'(d_ack), 64'(t.is_d));
            exp_rd = (to_mode || t.wr) ? 32'h0 : ref_mem[t.addr[5:2]];
            chk("ack_rdata", 64'(d_ack ? d_rdata : if_rdata), 64'(exp_rd));
            chk("ack_err", 64'(d_ack ? d_err : if_err), 64'(to_mode));
            chk("ack_lat", 64'(cyc - iss_cyc), 64'(to_mode ? int'(TO) + 1 : cur_busy + 2));
            if (t.wr && !to_mode) ref_mem[t.addr[5:2]] = t.wdata;
          end
        end else begin
          chk("err_idle", 64'({if_err, d_err}), 64'(0));
        end
        p_mr  = mem_req;
        p_ei  = if_req && !if_ack;
        p_ed  = d_req && !d_ack;
        p_ia  = if_addr;
        p_da  = d_addr;
        p_dw  = d_wdata;
        p_dwr = d_is_write;
      end
    end
  end

  // One access; scrambles the request inputs once granted to show the latched copy is used
  task automatic access(input bit is_d, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wdata, output int lat, output int mr,
                        output int bad, output int oth, output logic [31:0] rd,
                        output logic er);
    bit seen;
    lat = 0; mr = 0; bad = 0; oth = 0; seen = 0;
    if (is_d) begin
      d_addr = addr; d_is_write = wr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    do begin
      tick();
      lat++;
      if (mem_req) mr++;
      oth += is_d ? int'(if_ack) : int'(d_ack);
      if (mem_req && !seen) begin
        seen = 1;
        if (is_d) begin d_addr = ~addr; d_wdata = ~wdata; d_is_write = !wr; end
        else if_addr = ~addr;
      end
      if (seen)
        bad += int'((mem_addr != addr) || (mem_is_write != (is_d && wr)) ||
                    (is_d && (mem_data_out != wdata)));
    end while (!(is_d ? d_ack : if_ack) && lat < 60);
    if (is_d) d_req = 1'b0;
    else if_req = 1'b0;
    rd = is_d ? d_rdata : if_rdata;
    er = is_d ? d_err : if_err;
  endtask

  // Free-running master: n requests, re-raising req 0..maxgap cycles after each ack
  task automatic master(input bit is_d, input int n, input int maxgap);
    int w;
    for (int k = 0; k < n; k++) begin
      if (is_d) begin
        d_addr = rnd_addr(); d_is_write = 1'($urandom_range(0, 1));
        d_wdata = $urandom; d_req = 1'b1;
      end else begin
        if_addr = rnd_addr(); if_req = 1'b1;
      end
      w = 0;
      do begin tick(); w++; end while (!(is_d ? d_ack : if_ack) && w < 100);
      chk(is_d ? "d_ack_wait" : "if_ack_wait", 64'(is_d ? d_ack : if_ack), 64'(1));
      if (is_d) d_req = 1'b0;
      else if_req = 1'b0;
      tick();
      repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  initial begin : main
    int          lat, mr, bad, oth, w, acks;
    logic [31:0] rd;
    logic        er;
    logic [5:0]  ord;
    rst = 1'b1; if_req = 0; d_req = 0; d_is_write = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      ctl_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i] = ctl_mem[i];
    end
    ctl_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ctrl", 64'({if_ack, if_err, d_ack, d_err, mem_req, mem_is_write}), 64'(0));
    chk("rst_rdata", {if_rdata, d_rdata}, 64'(0));
    chk("rst_mem", {mem_addr, mem_data_out}, 64'(0));

    access(1'b1, 32'h10, 1'b0, 32'h0, lat, mr, bad, oth, rd, er);
    chk("rd_lat", 64'(lat), 64'(4));
    chk("rd_mreq_cycles", 64'(mr), 64'(1));
    chk("rd_stable", 64'(bad), 64'(0));
    chk("rd_if_ack", 64'(oth), 64'(0));
    chk("rd_data", 64'(rd), 64'(32'hDEAD_BEEF));
    chk("rd_err", 64'(er), 64'(0));
    tick();

    access(1'b1, 32'h20, 1'b1, 32'h1234_5678, lat, mr, bad, oth, rd, er);
    chk("wr_lat", 64'(lat), 64'(4));
    chk("wr_mreq_cycles", 64'(mr), 64'(1));
    chk("wr_stable", 64'(bad), 64'(0));
    chk("wr_rdata", 64'(rd), 64'(0));
    tick();

    hold_busy = 1'b1;
    fork
      access(1'b1, 32'h24, 1'b0, 32'hA5A5_A5A5, lat, mr, bad, oth, rd, er);
      begin
        w = 0;
        while (!mem_req && w < 20) begin tick(); w++; end
        repeat (3) tick();
        hold_busy = 1'b0;
      end
    join
    chk("bi_lat", 64'(lat), 64'(7));
    chk("bi_mreq_cycles", 64'(mr), 64'(4));
    chk("bi_stable", 64'(bad), 64'(0));
    chk("bi_data", 64'(rd), 64'(32'h1909_0909));
    tick();

    cfg_busy = 20;
    to_mode = 1'b1;
    access(1'b0, 32'h8, 1'b0, 32'h0, lat, mr, bad, oth, rd, er);
    chk("to_lat", 64'(lat), 64'(10));
    chk("to_err", 64'(er), 64'(1));
    chk("to_rdata", 64'(rd), 64'(0));
    chk("to_stable", 64'(bad), 64'(0));
    tick();
    chk("to_err_clear", 64'(if_err), 64'(0));
    to_mode = 1'b0;
    repeat (16) tick();
    cfg_busy = 1;
    access(1'b0, 32'h4, 1'b0, 32'h0, lat, mr, bad, oth, rd, er);
    chk("to_next_lat", 64'(lat), 64'(4));
    chk("to_next_err", 64'(er), 64'(0));
    chk("to_next_rdata", 64'(rd), 64'(32'h1101_0101));
    tick();

    cfg_busy = 5;
    d_is_write = 1'b0; d_addr = 32'h30; d_req = 1'b1;
    w = 0;
    while (!mem_req && w < 20) begin tick(); w++; end
    while (mem_req && w < 40) begin tick(); w++; end
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rm_ctrl", 64'({if_ack, if_err, d_ack, d_err, mem_req, mem_is_write}), 64'(0));
    chk("rm_rdata", {if_rdata, d_rdata}, 64'(0));
    chk("rm_mem", {mem_addr, mem_data_out}, 64'(0));
    acks = 0;
    repeat (10) begin tick(); acks += int'(if_ack) + int'(d_ack); end
    chk("rm_noack", 64'(acks), 64'(0));
    cfg_busy = 1;
    access(1'b1, 32'h30, 1'b0, 32'h0, lat, mr, bad, oth, rd, er);
    chk("rm_next_lat", 64'(lat), 64'(4));
    chk("rm_next_rdata", 64'(rd), 64'(32'h1C0C_0C0C));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_log.delete();
    fork
      master(1'b0, 3, 0);
      master(1'b1, 3, 0);
    join
    for (int i = 0; i < 6; i++) ord[5-i] = (i < ack_log.size()) ? ack_log[i] : 1'b0;
    chk("order_len", 64'(ack_log.size()), 64'(6));
    chk("order", 64'(ord), 64'(6'b101010));

    tick();
    cfg_rand = 1'b1;
    fork
      master(1'b0, 15, 4);
      master(1'b1, 15, 4);
    join
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter between the CPU's instruction-fetch and data-access ports and the single physical memory controller port.
- Serialises requests with round-robin fairness.
- Holds each access stable across the controller's busy window.
- Returns read data and a one-cycle acknowledge to the winning master.
- A watchdog aborts accesses that stay busy too long and flags an error.

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_WIDTH  fetch address (read only)
- if_rdata  out  DATA_WIDTH  fetch read data; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  timeout flag; valid with if_ack
- d_req  in  1  data request; held high until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_is_write  in  1  1 = store
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  timeout flag; valid with d_ack
- mem_req  out  1  issue strobe to the controller
- mem_addr  out  ADDR_WIDTH  latched address
- mem_is_write  out  1  latched direction
- mem_data_out  out  DATA_WIDTH  latched store data
- mem_data_in  in  DATA_WIDTH  controller read data
- mem_busy  in  1  controller busy

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. All outputs 0 (acks, errs, rdata, mem_req, mem_addr, mem_is_write, mem_data_out). last_grant=IF, so the first tie goes to D. Watchdog counter = 0.
- Reset mid-access: the access is abandoned and no ack is issued. The controller is expected to be reset alongside.
- Controller protocol:
  - Issue = a cycle with mem_req=1 and mem_busy=0.
  - The controller raises mem_busy the next cycle and holds it high for 1 or more cycles.
  - The first cycle afterwards with mem_busy=0 is completion; mem_data_in is valid then.
- IDLE:
  - Eligible masters: req=1 and own ack not high this cycle. A master must drop req in its ack cycle.
  - If neither is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the master that is not last_grant.
  - On grant: latch addr, is_write (forced 0 for IF) and wdata into the mem_* registers; update last_grant; go to ISSUE.
- ISSUE:
  - Drive mem_req=1.
  - If mem_busy=0 this cycle, go to WAIT and clear the counter.
  - Otherwise stay in ISSUE, keeping mem_req=1 and mem_* stable.
- WAIT:
  - mem_req=0; mem_* held stable.
  - The first WAIT cycle is treated as busy regardless of mem_busy.
  - From the second WAIT cycle on, mem_busy=0 completes the access:
    - Register mem_data_in into the granted master's rdata (0 for writes).
    - Pulse that master's ack for one cycle, err=0.
    - Go to IDLE.
  - The counter increments every WAIT cycle. On reaching TIMEOUT_CYCLES with mem_busy still 1:
    - Pulse ack with err=1 and rdata=0.
    - Go to IDLE.
- Outputs while idle:
  - rdata is held until that master's next ack.
  - err is cleared the cycle after the ack.
  - mem_* hold their last values between accesses.
- Latency:
  - Request to ack is 4 cycles with a 1-cycle busy window: req sampled in cycle 0, ISSUE in 1, WAIT in 2–3, ack in 4.
  - Each extra busy cycle adds 1.
- Throughput:
  - A master may raise req again the cycle after its ack; it is sampled at the end of that cycle.
  - The other master can be granted in the ack cycle itself.
- Request changes: address or data changes while req is high are ignored after grant; the latched values are used.
- Fairness: with both masters permanently requesting, grants strictly alternate D, IF, D, IF…

Test Plan:
- Single read: d_req, d_addr=0x00000010, is_write=0, controller busy 1 cycle, returns 0xDEADBEEF.
  -> mem_req high exactly 1 cycle with mem_addr=0x10; d_ack 4 cycles after request with d_rdata=0xDEADBEEF; if_ack stays 0.
- Write: d_is_write=1, d_wdata=0x12345678, addr 0x20.
  -> mem_is_write=1, mem_data_out=0x12345678 stable from ISSUE through ack; d_rdata=0 at ack.
- Contention: if_req and d_req raised together after reset, each re-requesting immediately after its ack, 6 accesses.
  -> grant order D, IF, D, IF, D, IF; no ack cycle is shared.
- Busy at issue: mem_busy held high 3 cycles when ISSUE is entered.
  -> mem_req stays high all 3 cycles, issue occurs on the 4th; ack follows correctly.
- Timeout: TIMEOUT_CYCLES=8, mem_busy stuck high.
  -> if_ack with if_err=1 and if_rdata=0 after 8 WAIT cycles; a following request completes normally with err=0.
- Reset during WAIT: assert rst for one cycle mid-access.
  -> no ack; all outputs 0 the next cycle; state IDLE; a fresh request is serviced normally.
